pte_mem_port: RTL and testbench

- Memory-side port for the page-table walker.
- Accepts one-shot PTE read requests (L1/L0 walk fetches) and PTE A/D writeback requests from the MMU, and serialises them onto the DRAM request channel.
- Returns read data with a busy/done handshake.
- Holds a one-entry writeback buffer and a one-entry last-PTE cache, so repeated walks of the same L1 entry skip DRAM.

---
 rtl/pte_mem_port_pkg.sv | 32 +++
 rtl/pte_last_cache.sv | 72 +++++++
 rtl/pte_mem_port.sv | 239 +++++++++++++++++++++++
 tb/tb_pte_mem_port.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pte_mem_port_pkg.sv
// -----------------------------------------------------------------------------
// pte_mem_port_pkg
//   Shared definitions for the page-table-walker memory port: bus widths,
//   FSM state encoding, timeout default, last-PTE cache defaults and a
//   word-alignment helper used wherever a PTE address is captured.
// -----------------------------------------------------------------------------
package pte_mem_port_pkg;

  localparam int unsigned PTE_AW = 32;
  localparam int unsigned PTE_DW = 32;

  // Cycles spent waiting for a DRAM response before the transaction aborts.
  localparam int unsigned PTE_TIMEOUT_DEFAULT = 1023;

  // Last-read PTE cache enabled by default.
  localparam bit PTE_CACHE_EN_DEFAULT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } pte_state_e;

  // PTEs are 4-byte aligned; the low two address bits carry no meaning.
  function automatic logic [PTE_AW-1:0] pte_word_align(input logic [PTE_AW-1:0] addr);
    return addr & {{(PTE_AW-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/pte_last_cache.sv
// -----------------------------------------------------------------------------
// pte_last_cache
//   One-entry cache of the most recently fetched PTE.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     flush_i             invalidate the entry this cycle (also masks hit_o)
//     lookup_addr_i       word-aligned address to look up
//     hit_o, hit_data_o   lookup result and cached PTE
//     fill_i/_addr/_data  install a freshly read PTE
//     wt_i/_addr/_data    retired write; updates the entry if the address matches
// -----------------------------------------------------------------------------
module pte_last_cache
  import pte_mem_port_pkg::*;
#(
  parameter bit EN = PTE_CACHE_EN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [PTE_AW-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [PTE_DW-1:0] hit_data_o,
  input  logic              fill_i,
  input  logic [PTE_AW-1:0] fill_addr_i,
  input  logic [PTE_DW-1:0] fill_data_i,
  input  logic              wt_i,
  input  logic [PTE_AW-1:0] wt_addr_i,
  input  logic [PTE_DW-1:0] wt_data_i
);

  logic              valid_q, valid_d;
  logic [PTE_AW-1:0] addr_q,  addr_d;
  logic [PTE_DW-1:0] data_q,  data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      addr_d  = fill_addr_i;
      data_d  = fill_data_i;
    end else if (wt_i && valid_q && (addr_q == wt_addr_i)) begin
      data_d = wt_data_i;
    end
    // Flush wins over a same-cycle fill or write-through.
    if (flush_i || !EN) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the payload is storage, not control; valid_q alone gates its use, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // A same-cycle flush must not let a stale entry satisfy a lookup.
  assign hit_o      = EN && valid_q && !flush_i && (addr_q == lookup_addr_i);
  assign hit_data_o = data_q;

endmodule

// File: rtl/pte_mem_port.sv
// -----------------------------------------------------------------------------
// pte_mem_port
//   Memory-side port of the page-table walker. Captures one-shot PTE reads
//   and A/D writebacks, serialises them onto the DRAM request channel (writes
//   first) and returns read data with a done pulse. A one-entry last-PTE cache
//   lets repeated walks of the same entry skip DRAM.
//   Ports:
//     CLK, RST_X                 clock, asynchronous active-low reset
//     i_rd_req/i_rd_addr         PTE read request pulse and address
//     i_wr_req/i_wr_addr/i_wr_data  writeback request pulse, address, data
//     i_flush                    invalidate the PTE cache
//     o_busy                     FSM active, write buffered or read pending
//     o_rd_done/o_rdata          read completion pulse and held read data
//     o_err                      timeout abort pulse
//     o_mem_req/we/addr/wdata    DRAM request channel (held until i_mem_gnt)
//     i_mem_gnt/rvalid/rdata/wack  DRAM responses
// -----------------------------------------------------------------------------
module pte_mem_port
  import pte_mem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PTE_TIMEOUT_DEFAULT,
  parameter bit          PTE_CACHE_EN   = PTE_CACHE_EN_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              i_rd_req,
  input  logic [PTE_AW-1:0] i_rd_addr,
  input  logic              i_wr_req,
  input  logic [PTE_AW-1:0] i_wr_addr,
  input  logic [PTE_DW-1:0] i_wr_data,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_rd_done,
  output logic [PTE_DW-1:0] o_rdata,
  output logic              o_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [PTE_AW-1:0] o_mem_addr,
  output logic [PTE_DW-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [PTE_DW-1:0] i_mem_rdata,
  input  logic              i_mem_wack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  pte_state_e        state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [PTE_AW-1:0] wb_addr_q,  wb_addr_d;
  logic [PTE_DW-1:0] wb_data_q,  wb_data_d;
  logic              rd_pend_q,  rd_pend_d;
  logic [PTE_AW-1:0] rd_addr_q,  rd_addr_d;
  logic [PTE_DW-1:0] rdata_q,    rdata_d;
  logic              rd_done_q,  rd_done_d;
  logic              err_q,      err_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  // Set when a flush lands while a DRAM read is outstanding: its data is
  // still returned but must not repopulate the cache.
  logic              no_fill_q,  no_fill_d;

  logic              cache_hit;
  logic [PTE_DW-1:0] cache_data;
  logic              cache_fill;
  logic              cache_wt;

  pte_last_cache #(
    .EN (PTE_CACHE_EN)
  ) u_cache (
    .clk           (CLK),
    .rst_n         (RST_X),
    .flush_i       (i_flush),
    .lookup_addr_i (rd_addr_q),
    .hit_o         (cache_hit),
    .hit_data_o    (cache_data),
    .fill_i        (cache_fill),
    .fill_addr_i   (rd_addr_q),
    .fill_data_i   (i_mem_rdata),
    .wt_i          (cache_wt),
    .wt_addr_i     (wb_addr_q),
    .wt_data_i     (wb_data_q)
  );

  always_comb begin
    state_d     = state_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    rdata_d     = rdata_q;
    rd_done_d   = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    no_fill_d   = no_fill_q;
    cache_fill  = 1'b0;
    cache_wt    = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;

    // Capture runs in every state. A request arriving while its slot is
    // already occupied is dropped; the slot is never cleared in that same
    // cycle's capture path, so the two updates cannot collide.
    if (i_wr_req && !wb_valid_q) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = pte_word_align(i_wr_addr);
      wb_data_d  = i_wr_data;
    end
    if (i_rd_req && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = pte_word_align(i_rd_addr);
    end

    if (i_flush && ((state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT))) begin
      no_fill_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        no_fill_d = 1'b0;
        // Writes drain first so a later read observes the update.
        if (wb_valid_q) begin
          state_d = ST_WR_REQ;
        end else if (rd_pend_q && cache_hit) begin
          rdata_d   = cache_data;
          rd_done_d = 1'b1;
          rd_pend_d = 1'b0;
        end else if (rd_pend_q) begin
          state_d = ST_RD_REQ;
        end
      end

      ST_WR_REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = wb_addr_q;
        o_mem_wdata = wb_data_q;
        if (i_mem_gnt) begin
          state_d = ST_WR_WAIT;
          cnt_d   = '0;
        end
      end

      ST_WR_WAIT: begin
        if (i_mem_wack) begin
          wb_valid_d = 1'b0;
          cache_wt   = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d = 1'b0;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = rd_addr_q;
        if (i_mem_gnt) begin
          state_d = ST_RD_WAIT;
          cnt_d   = '0;
        end
      end

      ST_RD_WAIT: begin
        if (i_mem_rvalid) begin
          rdata_d    = i_mem_rdata;
          cache_fill = !no_fill_q && !i_flush;
          rd_pend_d  = 1'b0;
          rd_done_d  = 1'b1;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          rd_pend_d = 1'b0;
          rd_done_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // o_rd_done (and o_err on abort) are high for this single cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rd_done_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      no_fill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rd_done_q  <= rd_done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      no_fill_q  <= no_fill_d;
    end
  end

  assign o_busy    = (state_q != ST_IDLE) || wb_valid_q || rd_pend_q;
  assign o_rd_done = rd_done_q;
  assign o_rdata   = rdata_q;
  assign o_err     = err_q;

  // Requesters must wait for completion before issuing another request of
  // the same kind; overlapping requests are dropped above.
  a_no_rd_overlap: assert property (@(posedge CLK) disable iff (!RST_X)
    !(i_rd_req && rd_pend_q));
  a_no_wr_overlap: assert property (@(posedge CLK) disable iff (!RST_X)
    !(i_wr_req && wb_valid_q));

endmodule

// File: tb/tb_pte_mem_port.sv
// -----------------------------------------------------------------------------
// tb_pte_mem_port
//   Directed self-checking bench for pte_mem_port with TIMEOUT_CYCLES = 8.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_pte_mem_port;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        i_rd_req = 1'b0;
  logic [31:0] i_rd_addr = '0;
  logic        i_wr_req = 1'b0;
  logic [31:0] i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_flush = 1'b0;
  logic        o_busy;
  logic        o_rd_done;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_wack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_gnts  = 0;
  int wr_gnts  = 0;

  pte_mem_port #(
    .TIMEOUT_CYCLES (8),
    .PTE_CACHE_EN   (1'b1)
  ) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .i_rd_req     (i_rd_req),
    .i_rd_addr    (i_rd_addr),
    .i_wr_req     (i_wr_req),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_flush      (i_flush),
    .o_busy       (o_busy),
    .o_rd_done    (o_rd_done),
    .o_rdata      (o_rdata),
    .o_err        (o_err),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_wack   (i_mem_wack)
  );

  always #5 CLK = ~CLK;

  // Count accepted DRAM requests by direction.
  always @(posedge CLK) begin
    if (RST_X && o_mem_req && i_mem_gnt) begin
      if (o_mem_we) wr_gnts++;
      else          rd_gnts++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rd(input logic [31:0] addr);
    i_rd_req  = 1'b1;
    i_rd_addr = addr;
    step();
    i_rd_req  = 1'b0;
  endtask

  initial begin
    int n;

    // ---------------- reset ----------------
    step();
    step();
    check("rst_busy",    32'(o_busy),    32'd0);
    check("rst_done",    32'(o_rd_done), 32'd0);
    check("rst_err",     32'(o_err),     32'd0);
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_rdata",   o_rdata,        32'd0);
    RST_X = 1'b1;
    step();

    // ---------------- read miss ----------------
    pulse_rd(32'h8000_1004);
    check("miss_busy_after_req", 32'(o_busy),    32'd1);
    check("miss_no_req_yet",     32'(o_mem_req), 32'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      check("miss_req",  32'(o_mem_req), 32'd1);
      check("miss_we",   32'(o_mem_we),  32'd0);
      check("miss_addr", o_mem_addr,     32'h8000_1004);
      step();
    end
    check("miss_req_gnt_cycle", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    check("miss_req_dropped", 32'(o_mem_req), 32'd0);
    step();
    step();
    check("miss_no_early_done", 32'(o_rd_done), 32'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h2000_0C01;
    step();
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    check("miss_done",  32'(o_rd_done), 32'd1);
    check("miss_rdata", o_rdata,        32'h2000_0C01);
    check("miss_err",   32'(o_err),     32'd0);
    step();
    check("miss_done_pulse", 32'(o_rd_done), 32'd0);
    check("miss_busy_low",   32'(o_busy),    32'd0);
    check("miss_rd_count",   32'(rd_gnts),   32'd1);

    // ---------------- cache hit ----------------
    pulse_rd(32'h8000_1004);
    check("hit_no_done_yet", 32'(o_rd_done), 32'd0);
    check("hit_busy",        32'(o_busy),    32'd1);
    check("hit_no_mem_req",  32'(o_mem_req), 32'd0);
    step();
    check("hit_done",       32'(o_rd_done), 32'd1);
    check("hit_rdata",      o_rdata,        32'h2000_0C01);
    check("hit_no_mem_req2", 32'(o_mem_req), 32'd0);
    step();
    check("hit_done_pulse", 32'(o_rd_done), 32'd0);
    check("hit_rd_count",   32'(rd_gnts),   32'd1);

    // ---------------- flush then re-read (low bits ignored) ----------------
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    pulse_rd(32'h8000_1006);
    step();
    check("flush_miss_req",  32'(o_mem_req), 32'd1);
    check("flush_miss_addr", o_mem_addr,     32'h8000_1004);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h2000_0C02;
    step();
    i_mem_rvalid = 1'b0;
    check("flush_miss_done",  32'(o_rd_done), 32'd1);
    check("flush_miss_rdata", o_rdata,        32'h2000_0C02);
    check("flush_rd_count",   32'(rd_gnts),   32'd2);
    step();

    // ---------------- simultaneous write + read ----------------
    i_wr_req  = 1'b1;
    i_wr_addr = 32'h8000_1004;
    i_wr_data = 32'h2000_0CC1;
    i_rd_req  = 1'b1;
    i_rd_addr = 32'h8000_1004;
    step();
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    check("sim_busy", 32'(o_busy), 32'd1);
    step();
    check("sim_wr_first_req", 32'(o_mem_req),  32'd1);
    check("sim_wr_first_we",  32'(o_mem_we),   32'd1);
    check("sim_wr_addr",      o_mem_addr,      32'h8000_1004);
    check("sim_wr_data",      o_mem_wdata,     32'h2000_0CC1);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    check("sim_wr_wait_no_req", 32'(o_mem_req), 32'd0);
    i_mem_wack = 1'b1;
    step();
    i_mem_wack = 1'b0;
    check("sim_rd_no_done_yet", 32'(o_rd_done), 32'd0);
    check("sim_rd_no_mem_req",  32'(o_mem_req), 32'd0);
    step();
    check("sim_rd_done",   32'(o_rd_done), 32'd1);
    check("sim_rd_wt_data", o_rdata,       32'h2000_0CC1);
    check("sim_rd_count",  32'(rd_gnts),   32'd2);
    check("sim_wr_count",  32'(wr_gnts),   32'd1);
    step();
    check("sim_busy_low", 32'(o_busy), 32'd0);

    // ---------------- read timeout ----------------
    pulse_rd(32'h8000_2008);
    step();
    check("tmo_req", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    n = 0;
    while (!o_rd_done && n < 20) begin
      check("tmo_no_err_early", 32'(o_err), 32'd0);
      step();
      n++;
    end
    check("tmo_cycles", 32'(n),         32'd8);
    check("tmo_done",   32'(o_rd_done), 32'd1);
    check("tmo_err",    32'(o_err),     32'd1);
    check("tmo_rdata",  o_rdata,        32'd0);
    step();
    check("tmo_err_pulse", 32'(o_err), 32'd0);
    pulse_rd(32'h8000_2008);
    step();
    check("tmo_rereq_misses", 32'(o_mem_req), 32'd1);
    check("tmo_rereq_addr",   o_mem_addr,     32'h8000_2008);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h1234_5678;
    step();
    i_mem_rvalid = 1'b0;
    check("tmo_rereq_rdata", o_rdata, 32'h1234_5678);
    step();

    // ---------------- reset mid RD_WAIT ----------------
    pulse_rd(32'h8000_3000);
    step();
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    step();
    RST_X = 1'b0;
    #1;
    check("mrst_busy",    32'(o_busy),    32'd0);
    check("mrst_done",    32'(o_rd_done), 32'd0);
    check("mrst_mem_req", 32'(o_mem_req), 32'd0);
    check("mrst_rdata",   o_rdata,        32'd0);
    step();
    RST_X        = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hDEAD_BEEF;
    step();
    i_mem_rvalid = 1'b0;
    check("mrst_late_no_done", 32'(o_rd_done), 32'd0);
    check("mrst_late_busy",    32'(o_busy),    32'd0);
    step();
    check("mrst_late_no_done2", 32'(o_rd_done), 32'd0);
    check("mrst_rdata_held0",   o_rdata,        32'd0);
    pulse_rd(32'h8000_2008);
    step();
    check("mrst_cache_empty", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h0BAD_F00D;
    step();
    i_mem_rvalid = 1'b0;
    check("mrst_reread_rdata", o_rdata, 32'h0BAD_F00D);
    step();

    // ---------------- write backpressure ----------------
    n = wr_gnts;
    i_wr_req  = 1'b1;
    i_wr_addr = 32'h8000_4011;
    i_wr_data = 32'hA5A5_0001;
    step();
    i_wr_req = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_req",   32'(o_mem_req), 32'd1);
      check("bp_we",    32'(o_mem_we),  32'd1);
      check("bp_addr",  o_mem_addr,     32'h8000_4010);
      check("bp_wdata", o_mem_wdata,    32'hA5A5_0001);
      step();
    end
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    check("bp_one_write", 32'(wr_gnts - n), 32'd1);
    check("bp_req_gone",  32'(o_mem_req),   32'd0);
    i_mem_wack = 1'b1;
    step();
    i_mem_wack = 1'b0;
    check("bp_busy_low", 32'(o_busy), 32'd0);
    check("bp_no_err",   32'(o_err),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
